// File: rtl/bh1750_pkg.sv
// Shared constants for the BH1750 I2C target model.
// Opcodes, default address and controller state encoding.
package bh1750_pkg;

    localparam logic [6:0] DEV_ADDR_DEF = 7'h23;

    localparam logic [7:0] OP_PWR_DOWN = 8'h00;
    localparam logic [7:0] OP_PWR_ON   = 8'h01;
    localparam logic [7:0] OP_RESET    = 8'h07;
    localparam logic [7:0] OP_CONT_H   = 8'h10;
    localparam logic [7:0] OP_CONT_H2  = 8'h11;
    localparam logic [7:0] OP_CONT_L   = 8'h13;
    localparam logic [7:0] OP_ONCE_H   = 8'h20;
    localparam logic [7:0] OP_ONCE_H2  = 8'h21;
    localparam logic [7:0] OP_ONCE_L   = 8'h23;

    localparam logic [2:0] ST_IDLE      = 3'd0;
    localparam logic [2:0] ST_ADDR      = 3'd1;
    localparam logic [2:0] ST_ADDR_ACK  = 3'd2;
    localparam logic [2:0] ST_CMD       = 3'd3;
    localparam logic [2:0] ST_CMD_ACK   = 3'd4;
    localparam logic [2:0] ST_TX        = 3'd5;
    localparam logic [2:0] ST_TX_ACK    = 3'd6;
    localparam logic [2:0] ST_WAIT_STOP = 3'd7;

    function automatic logic is_cont(input logic [7:0] op);
        return op == OP_CONT_H || op == OP_CONT_H2 || op == OP_CONT_L;
    endfunction

    function automatic logic is_once(input logic [7:0] op);
        return op == OP_ONCE_H || op == OP_ONCE_H2 || op == OP_ONCE_L;
    endfunction

endpackage

// File: rtl/bh1750_if.sv
// Sensor-side bundle of the BH1750 target: SCL, measurement feed and status.
// The open-drain SDA line stays a plain inout on the target.
interface bh1750_if;
    logic        scl;
    logic [15:0] lux_in;
    logic        lux_valid;
    logic        power_on;
    logic        meas_active;
    logic [7:0]  cmd_out;
    logic        cmd_stb;
    logic        busy;

    modport master (
        output scl, lux_in, lux_valid,
        input  power_on, meas_active, cmd_out, cmd_stb, busy
    );

    modport slave (
        input  scl, lux_in, lux_valid,
        output power_on, meas_active, cmd_out, cmd_stb, busy
    );
endinterface

// File: rtl/bh1750_i2c_line_sync.sv
// SCL/SDA synchronizers with edge and START/STOP detection.
// Outputs are pulses one clk wide, derived from synced levels only.
module i2c_line_sync #(
    parameter int SYNC_FF = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic scl,
    input  logic sda,
    output logic sda_s,
    output logic scl_rise,
    output logic scl_fall,
    output logic start_det,
    output logic stop_det
);
    logic [SYNC_FF-1:0] scl_ff;
    logic [SYNC_FF-1:0] sda_ff;
    logic               scl_q;
    logic               sda_q;
    logic               scl_s;

    // Reset to the idle-bus level so leaving reset never fakes an edge.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            scl_ff <= '1;
            sda_ff <= '1;
            scl_q  <= 1'b1;
            sda_q  <= 1'b1;
        end else begin
            scl_ff <= {scl_ff[SYNC_FF-2:0], scl};
            sda_ff <= {sda_ff[SYNC_FF-2:0], sda};
            scl_q  <= scl_ff[SYNC_FF-1];
            sda_q  <= sda_ff[SYNC_FF-1];
        end
    end

    assign scl_s     = scl_ff[SYNC_FF-1];
    assign sda_s     = sda_ff[SYNC_FF-1];
    assign scl_rise  = scl_s & ~scl_q;
    assign scl_fall  = ~scl_s & scl_q;
    assign start_det = scl_s & scl_q & sda_q & ~sda_s;
    assign stop_det  = scl_s & scl_q & ~sda_q & sda_s;
endmodule

// File: rtl/bh1750_i2c_target.sv
// BH1750 ambient-light sensor emulation as an I2C target.
// Decodes mode commands, latches conversions and returns 16-bit results.
module bh1750_i2c_target
    import bh1750_pkg::*;
#(
    parameter logic [6:0] DEV_ADDR = DEV_ADDR_DEF,
    parameter int         SYNC_FF  = 2
) (
    input  logic     clk,
    input  logic     rst,
    inout  wire      sda,
    bh1750_if.slave  bus
);
    logic        sda_s;
    logic        scl_rise;
    logic        scl_fall;
    logic        start_det;
    logic        stop_det;

    logic [2:0]  state;
    logic [3:0]  cnt;
    logic [7:0]  rx;
    logic [15:0] tx;
    logic        rw;
    logic        lo_byte;
    logic        ack_n;
    logic        sda_oe;
    logic [15:0] data_reg;
    logic        one_shot;
    logic        power_on;
    logic        meas_active;
    logic [7:0]  cmd_out;
    logic        cmd_stb;
    logic        busy;

    i2c_line_sync #(.SYNC_FF(SYNC_FF)) u_sync (
        .clk       (clk),
        .rst       (rst),
        .scl       (bus.scl),
        .sda       (sda),
        .sda_s     (sda_s),
        .scl_rise  (scl_rise),
        .scl_fall  (scl_fall),
        .start_det (start_det),
        .stop_det  (stop_det)
    );

    assign sda = sda_oe ? 1'b0 : 1'bz;

    assign bus.power_on    = power_on;
    assign bus.meas_active = meas_active;
    assign bus.cmd_out     = cmd_out;
    assign bus.cmd_stb     = cmd_stb;
    assign bus.busy        = busy;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= ST_IDLE;
            cnt         <= 4'd0;
            rx          <= 8'h00;
            tx          <= 16'h0000;
            rw          <= 1'b0;
            lo_byte     <= 1'b0;
            ack_n       <= 1'b1;
            sda_oe      <= 1'b0;
            data_reg    <= 16'h0000;
            one_shot    <= 1'b0;
            power_on    <= 1'b0;
            meas_active <= 1'b0;
            cmd_out     <= 8'h00;
            cmd_stb     <= 1'b0;
            busy        <= 1'b0;
        end else begin
            cmd_stb <= 1'b0;

            if (bus.lux_valid && meas_active) begin
                data_reg <= bus.lux_in;
                if (one_shot) begin
                    meas_active <= 1'b0;
                    power_on    <= 1'b0;
                end
            end

            if (stop_det) begin
                state  <= ST_IDLE;
                sda_oe <= 1'b0;
                busy   <= 1'b0;
            end else if (start_det) begin
                state  <= ST_ADDR;
                cnt    <= 4'd0;
                sda_oe <= 1'b0;
            end else begin
                case (state)
                    ST_ADDR: begin
                        if (scl_rise) begin
                            rx  <= {rx[6:0], sda_s};
                            cnt <= cnt + 4'd1;
                        end else if (scl_fall && cnt == 4'd8) begin
                            if (rx[7:1] == DEV_ADDR) begin
                                state   <= ST_ADDR_ACK;
                                sda_oe  <= 1'b1;
                                busy    <= 1'b1;
                                rw      <= rx[0];
                                tx      <= data_reg;
                                lo_byte <= 1'b0;
                            end else begin
                                state <= ST_WAIT_STOP;
                                busy  <= 1'b0;
                            end
                        end
                    end
                    ST_ADDR_ACK: begin
                        if (scl_fall) begin
                            cnt <= 4'd0;
                            if (rw) begin
                                state  <= ST_TX;
                                sda_oe <= ~tx[15];
                            end else begin
                                state  <= ST_CMD;
                                sda_oe <= 1'b0;
                            end
                        end
                    end
                    ST_CMD: begin
                        if (scl_rise) begin
                            rx  <= {rx[6:0], sda_s};
                            cnt <= cnt + 4'd1;
                        end else if (scl_fall && cnt == 4'd8) begin
                            state   <= ST_CMD_ACK;
                            sda_oe  <= 1'b1;
                            cmd_out <= rx;
                            cmd_stb <= 1'b1;
                            // Placed after the lux update so a command wins a same-clk clash.
                            unique case (1'b1)
                                rx == OP_PWR_DOWN: begin
                                    power_on    <= 1'b0;
                                    meas_active <= 1'b0;
                                end
                                rx == OP_PWR_ON: power_on <= 1'b1;
                                rx == OP_RESET: begin
                                    if (power_on) data_reg <= 16'h0000;
                                end
                                is_cont(rx) || is_once(rx): begin
                                    power_on    <= 1'b1;
                                    meas_active <= 1'b1;
                                    one_shot    <= is_once(rx);
                                end
                                default: ;
                            endcase
                        end
                    end
                    ST_CMD_ACK: begin
                        if (scl_fall) begin
                            state  <= ST_CMD;
                            sda_oe <= 1'b0;
                            cnt    <= 4'd0;
                        end
                    end
                    ST_TX: begin
                        if (scl_fall) begin
                            tx <= {tx[14:0], 1'b0};
                            if (cnt == 4'd7) begin
                                state  <= ST_TX_ACK;
                                sda_oe <= 1'b0;
                                cnt    <= 4'd0;
                            end else begin
                                cnt    <= cnt + 4'd1;
                                sda_oe <= ~tx[14];
                            end
                        end
                    end
                    ST_TX_ACK: begin
                        if (scl_rise) begin
                            ack_n <= sda_s;
                        end else if (scl_fall) begin
                            if (ack_n) begin
                                state  <= ST_WAIT_STOP;
                                sda_oe <= 1'b0;
                            end else begin
                                state   <= ST_TX;
                                cnt     <= 4'd0;
                                lo_byte <= ~lo_byte;
                                // After the low byte a fresh result is snapshotted.
                                if (lo_byte) begin
                                    tx     <= data_reg;
                                    sda_oe <= ~data_reg[15];
                                end else begin
                                    sda_oe <= ~tx[15];
                                end
                            end
                        end
                    end
                    default: ;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_bh1750_i2c_target.sv
// Bench for the BH1750 I2C target: bit-banged initiator, vector table,
// randomized commands against a mode/result model, and corner sequences.
module tb_bh1750_i2c_target;

    localparam int Q = 8;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic m_oe = 1'b0;
    wire  sda;

    int errors = 0;
    int checks = 0;
    int stb_cnt = 0;
    int drv_cnt = 0;

    logic        mp, mm, mo;
    logic [15:0] md;

    bh1750_if bus ();

    assign sda = m_oe ? 1'b0 : 1'bz;
    pullup (sda);

    bh1750_i2c_target #(.DEV_ADDR(7'h23), .SYNC_FF(2)) dut (
        .clk (clk),
        .rst (rst),
        .sda (sda),
        .bus (bus)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (bus.cmd_stb) stb_cnt++;
        if (!m_oe && sda === 1'b0) drv_cnt++;
    end

    typedef struct {
        logic [7:0]  op;
        logic        pulse;
        logic [15:0] lux;
        logic        ep;
        logic        em;
        logic [15:0] ed;
    } vec_t;

    vec_t tbl [10];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic start_c();
        m_oe = 1'b0; tick(Q);
        bus.scl = 1'b1; tick(Q);
        m_oe = 1'b1; tick(Q);
        bus.scl = 1'b0; tick(Q);
    endtask

    task automatic stop_c();
        m_oe = 1'b1; tick(Q);
        bus.scl = 1'b1; tick(Q);
        m_oe = 1'b0; tick(2 * Q);
    endtask

    task automatic bit_x(input logic b, output logic r);
        m_oe = ~b; tick(Q);
        bus.scl = 1'b1; tick(Q);
        r = sda; tick(Q);
        bus.scl = 1'b0; tick(Q);
    endtask

    task automatic write_byte(input logic [7:0] d, output logic ack);
        logic r;
        for (int i = 7; i >= 0; i--) bit_x(d[i], r);
        bit_x(1'b1, r);
        ack = ~r;
    endtask

    task automatic read_byte(input logic mack, output logic [7:0] d);
        logic r;
        logic [7:0] t;
        t = 8'h00;
        for (int i = 0; i < 8; i++) begin
            bit_x(1'b1, r);
            t = {t[6:0], r};
        end
        bit_x(~mack, r);
        d = t;
    endtask

    task automatic wr_cmd(input logic [7:0] op, output logic a1, output logic a2);
        start_c();
        write_byte(8'h46, a1);
        write_byte(op, a2);
        stop_c();
    endtask

    task automatic rd_data(output logic a, output logic [15:0] d);
        logic [7:0] h, l;
        start_c();
        write_byte(8'h47, a);
        read_byte(1'b1, h);
        read_byte(1'b0, l);
        stop_c();
        d = {h, l};
    endtask

    task automatic lux_pulse(input logic [15:0] v);
        @(negedge clk);
        bus.lux_in = v;
        bus.lux_valid = 1'b1;
        @(negedge clk);
        bus.lux_valid = 1'b0;
    endtask

    task automatic m_reset();
        mp = 1'b0; mm = 1'b0; mo = 1'b0; md = 16'h0000;
    endtask

    task automatic m_cmd(input logic [7:0] op);
        case (op)
            8'h00: begin mp = 1'b0; mm = 1'b0; end
            8'h01: mp = 1'b1;
            8'h07: if (mp) md = 16'h0000;
            8'h10, 8'h11, 8'h13: begin mp = 1'b1; mm = 1'b1; mo = 1'b0; end
            8'h20, 8'h21, 8'h23: begin mp = 1'b1; mm = 1'b1; mo = 1'b1; end
            default: ;
        endcase
    endtask

    task automatic m_lux(input logic [15:0] v);
        if (mm) begin
            md = v;
            if (mo) begin mm = 1'b0; mp = 1'b0; end
        end
    endtask

    initial begin
        logic        a1, a2, r;
        logic [7:0]  op, h, l;
        logic [15:0] d, v;
        logic [7:0]  ops [9];
        int          s0, d0, k;

        ops = '{8'h00, 8'h01, 8'h07, 8'h10, 8'h11, 8'h13, 8'h20, 8'h21, 8'h23};
        tbl[0] = '{8'h01, 1'b0, 16'h0000, 1'b1, 1'b0, 16'h0000};
        tbl[1] = '{8'h13, 1'b1, 16'h1234, 1'b1, 1'b1, 16'h1234};
        tbl[2] = '{8'h23, 1'b1, 16'h00AA, 1'b0, 1'b0, 16'h00AA};
        tbl[3] = '{8'h55, 1'b1, 16'h5555, 1'b0, 1'b0, 16'h00AA};
        tbl[4] = '{8'h07, 1'b0, 16'h0000, 1'b0, 1'b0, 16'h00AA};
        tbl[5] = '{8'h01, 1'b0, 16'h0000, 1'b1, 1'b0, 16'h00AA};
        tbl[6] = '{8'h07, 1'b1, 16'h7777, 1'b1, 1'b0, 16'h0000};
        tbl[7] = '{8'h10, 1'b1, 16'hBEEF, 1'b1, 1'b1, 16'hBEEF};
        tbl[8] = '{8'h00, 1'b1, 16'h1111, 1'b0, 1'b0, 16'hBEEF};
        tbl[9] = '{8'h21, 1'b1, 16'h8001, 1'b0, 1'b0, 16'h8001};

        bus.scl = 1'b1;
        bus.lux_in = 16'h0000;
        bus.lux_valid = 1'b0;
        m_reset();
        tick(5);
        chk("rst_power_on", bus.power_on, 0);
        chk("rst_meas_active", bus.meas_active, 0);
        chk("rst_cmd_out", bus.cmd_out, 8'h00);
        chk("rst_cmd_stb", bus.cmd_stb, 0);
        chk("rst_busy", bus.busy, 0);
        chk("rst_sda", sda, 1);
        rst = 1'b1;
        tick(5);

        foreach (tbl[i]) begin
            s0 = stb_cnt;
            wr_cmd(tbl[i].op, a1, a2);
            chk("tbl_addr_ack", a1, 1);
            chk("tbl_cmd_ack", a2, 1);
            chk("tbl_cmd_out", bus.cmd_out, tbl[i].op);
            chk("tbl_stb_count", stb_cnt - s0, 1);
            m_cmd(tbl[i].op);
            if (tbl[i].pulse) begin
                lux_pulse(tbl[i].lux);
                m_lux(tbl[i].lux);
            end
            tick(2);
            chk("tbl_power_on", bus.power_on, tbl[i].ep);
            chk("tbl_meas_active", bus.meas_active, tbl[i].em);
            rd_data(a1, d);
            chk("tbl_rd_ack", a1, 1);
            chk("tbl_rd_data", d, tbl[i].ed);
            chk("tbl_busy_after_stop", bus.busy, 0);
        end

        for (int n = 0; n < 16; n++) begin
            k = $urandom_range(0, 9);
            op = (k == 9) ? 8'($urandom) : ops[k];
            wr_cmd(op, a1, a2);
            m_cmd(op);
            chk("rnd_cmd_ack", a2, 1);
            chk("rnd_cmd_out", bus.cmd_out, op);
            if ($urandom_range(0, 1) == 1) begin
                v = 16'($urandom);
                lux_pulse(v);
                m_lux(v);
            end
            tick(2);
            chk("rnd_power_on", bus.power_on, mp);
            chk("rnd_meas_active", bus.meas_active, mm);
            rd_data(a1, d);
            chk("rnd_rd_data", d, md);
        end

        wr_cmd(8'h00, a1, a2);
        m_cmd(8'h00);
        s0 = stb_cnt;
        d0 = drv_cnt;
        start_c();
        write_byte(8'h48, a1);
        chk("wrong_addr_nack", a1, 0);
        write_byte(8'h01, a2);
        chk("wrong_addr_cmd_nack", a2, 0);
        stop_c();
        chk("wrong_addr_stb", stb_cnt - s0, 0);
        chk("wrong_addr_drive", drv_cnt - d0, 0);
        chk("wrong_addr_power", bus.power_on, mp);
        chk("wrong_addr_cmd_out", bus.cmd_out, 8'h00);

        wr_cmd(8'h10, a1, a2);
        m_cmd(8'h10);
        lux_pulse(16'h0F0F);
        m_lux(16'h0F0F);
        start_c();
        write_byte(8'h46, a1);
        chk("rs_wr_ack", a1, 1);
        start_c();
        write_byte(8'h47, a2);
        chk("rs_rd_ack", a2, 1);
        chk("rs_busy", bus.busy, 1);
        read_byte(1'b1, h);
        chk("rs_hi0", h, 8'h0F);
        lux_pulse(16'hA55A);
        m_lux(16'hA55A);
        read_byte(1'b1, l);
        chk("rs_lo0", l, 8'h0F);
        read_byte(1'b1, h);
        chk("rs_hi1", h, md[15:8]);
        read_byte(1'b1, l);
        chk("rs_lo1", l, md[7:0]);
        bit_x(1'b1, r);
        chk("rs_bit7", r, 1);
        bit_x(1'b1, r);
        chk("rs_bit6", r, 0);
        stop_c();
        chk("mid_stop_busy", bus.busy, 0);
        chk("mid_stop_sda", sda, 1);

        wr_cmd(8'h10, a1, a2);
        m_cmd(8'h10);
        lux_pulse(16'h0000);
        m_lux(16'h0000);
        start_c();
        write_byte(8'h47, a1);
        bit_x(1'b1, r);
        bit_x(1'b1, r);
        chk("rst_mid_bit6", r, 0);
        m_oe = 1'b0;
        tick(Q);
        bus.scl = 1'b1;
        tick(Q / 2);
        chk("rst_mid_sda_low", sda, 0);
        rst = 1'b0;
        #1;
        chk("rst_mid_sda_rel", sda, 1);
        chk("rst_mid_power_on", bus.power_on, 0);
        chk("rst_mid_meas", bus.meas_active, 0);
        chk("rst_mid_cmd_out", bus.cmd_out, 8'h00);
        chk("rst_mid_cmd_stb", bus.cmd_stb, 0);
        chk("rst_mid_busy", bus.busy, 0);
        m_reset();
        tick(4);
        rst = 1'b1;
        tick(4);
        wr_cmd(8'h01, a1, a2);
        m_cmd(8'h01);
        chk("post_rst_ack", a1 & a2, 1);
        chk("post_rst_power", bus.power_on, mp);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
